// File: rtl/status_led_pkg.sv
// Shared definitions for the status LED blocks: code width, default timing
// and the blink coder FSM state encoding.
package status_led_pkg;

  localparam int CODE_WIDTH         = 4;
  localparam int PAUSE_TICKS_DEF    = 4;
  localparam int STRETCH_CYCLES_DEF = 1000000;

  typedef logic [CODE_WIDTH-1:0] code_t;
  typedef logic [1:0]            state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t BLINK_ON  = 2'd1;
  localparam state_t BLINK_OFF = 2'd2;
  localparam state_t PAUSE     = 2'd3;

endpackage

// File: rtl/pulse_stretcher.sv
// Retriggerable one-shot: trig (re)loads the counter, active is high while
// the counter is nonzero.
module pulse_stretcher #(
  parameter int STRETCH_CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic trig,
  output logic active
);

  localparam int CNT_W = (STRETCH_CYCLES < 2) ? 1 : $clog2(STRETCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(STRETCH_CYCLES);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      count <= '0;
    end else if (trig) begin
      count <= LOAD;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign active = (count != '0);

endmodule

// File: rtl/led_blink_coder.sv
// Drives a status LED: heartbeat with activity flash when idle, otherwise
// blinks the pending/active error code as a repeating group of pulses.
module led_blink_coder
  import status_led_pkg::*;
#(
  parameter int PAUSE_TICKS    = PAUSE_TICKS_DEF,
  parameter int STRETCH_CYCLES = STRETCH_CYCLES_DEF
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        pulse_in,
  input  logic [3:0]  err_code_in,
  input  logic        err_valid_in,
  input  logic        err_clear_in,
  input  logic        activity_in,
  output logic        led_out,
  output logic        busy_out
);

  localparam logic [3:0] PAUSE_LOAD = 4'(PAUSE_TICKS);

  logic       pulse_q, pulse_d, tick, stretch_active;
  state_t     state, state_n;
  logic       pend_valid, pend_valid_n;
  code_t      pend_code, pend_code_n, act_code, act_code_n;
  code_t      blink_cnt, blink_cnt_n, blink_dec;
  logic [3:0] pause_cnt, pause_cnt_n, pause_dec;

  pulse_stretcher #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_stretch (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .trig     (activity_in),
    .active   (stretch_active)
  );

  assign tick = pulse_q ^ pulse_d;

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_n      = state;
    pend_valid_n = pend_valid;
    pend_code_n  = pend_code;
    act_code_n   = act_code;
    blink_cnt_n  = blink_cnt;
    pause_cnt_n  = pause_cnt;
    blink_dec    = blink_cnt - code_t'(1);
    pause_dec    = pause_cnt - 4'd1;

    if (err_clear_in) begin
      state_n      = IDLE;
      pend_valid_n = 1'b0;
      pend_code_n  = '0;
      act_code_n   = '0;
      blink_cnt_n  = '0;
      pause_cnt_n  = '0;
    end else begin
      case (state)
        IDLE: if (tick && pend_valid) begin
          state_n      = BLINK_ON;
          act_code_n   = pend_code;
          blink_cnt_n  = pend_code;
          pend_valid_n = 1'b0;
        end
        BLINK_ON: if (tick) state_n = BLINK_OFF;
        BLINK_OFF: if (tick) begin
          blink_cnt_n = blink_dec;
          if (blink_dec == '0) begin
            state_n     = PAUSE;
            pause_cnt_n = PAUSE_LOAD;
          end else begin
            state_n = BLINK_ON;
          end
        end
        PAUSE: if (tick) begin
          pause_cnt_n = pause_dec;
          if (pause_dec == '0) begin
            state_n = BLINK_ON;
            if (pend_valid) begin
              act_code_n   = pend_code;
              blink_cnt_n  = pend_code;
              pend_valid_n = 1'b0;
            end else begin
              blink_cnt_n = act_code;
            end
          end
        end
        default: state_n = IDLE;
      endcase
      // Written after consumption so a same-cycle code survives as the next pending.
      if (err_valid_in && err_code_in != '0) begin
        pend_valid_n = 1'b1;
        pend_code_n  = err_code_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      pulse_q    <= 1'b0;
      pulse_d    <= 1'b0;
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_code  <= '0;
      act_code   <= '0;
      blink_cnt  <= '0;
      pause_cnt  <= '0;
      led_out    <= 1'b0;
      busy_out   <= 1'b0;
    end else begin
      pulse_q    <= pulse_in;
      pulse_d    <= pulse_q;
      state      <= state_n;
      pend_valid <= pend_valid_n;
      pend_code  <= pend_code_n;
      act_code   <= act_code_n;
      blink_cnt  <= blink_cnt_n;
      pause_cnt  <= pause_cnt_n;
      // Outputs come from next-state values so they land with the state flop.
      led_out    <= (state_n == IDLE) ? (pulse_in ^ stretch_active) : (state_n == BLINK_ON);
      busy_out   <= (state_n != IDLE) || pend_valid_n;
    end
  end

endmodule

// File: tb/tb_led_blink_coder.sv
// Scoreboard bench: stimulus pushes expected (cycle, led, busy) change events;
// a monitor pops one per observed output change and compares.
module tb_led_blink_coder;

  logic       clk_in = 1'b0;
  logic       reset_in = 1'b0;
  logic       pulse_in = 1'b0;
  logic [3:0] err_code_in = '0;
  logic       err_valid_in = 1'b0;
  logic       err_clear_in = 1'b0;
  logic       activity_in = 1'b0;
  logic       led_out, busy_out;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int   cyc;
    logic led;
    logic busy;
  } ev_t;
  ev_t exp_q[$];

  led_blink_coder #(.PAUSE_TICKS(2), .STRETCH_CYCLES(8)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .pulse_in     (pulse_in),
    .err_code_in  (err_code_in),
    .err_valid_in (err_valid_in),
    .err_clear_in (err_clear_in),
    .activity_in  (activity_in),
    .led_out      (led_out),
    .busy_out     (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Edge counter plus heartbeat stub: pulse toggles just after every 20th edge.
  initial begin
    forever begin
      @(posedge clk_in);
      cyc++;
      if (cyc % 20 == 0) begin
        #1 pulse_in = ~pulse_in;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input int c, input logic l, input logic b);
    ev_t e;
    e.cyc = c; e.led = l; e.busy = b;
    exp_q.push_back(e);
  endtask

  // Returns just after edge k-1, so anything driven now is sampled at edge k.
  task automatic goto_edge(input int k);
    while (cyc < k - 1) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  task automatic strobe_err(input int k, input logic [3:0] code, input logic clr);
    goto_edge(k);
    err_valid_in = 1'b1; err_code_in = code; err_clear_in = clr;
    @(posedge clk_in); #2;
    err_valid_in = 1'b0; err_code_in = '0; err_clear_in = 1'b0;
  endtask

  task automatic strobe_clear(input int k);
    goto_edge(k);
    err_clear_in = 1'b1;
    @(posedge clk_in); #2;
    err_clear_in = 1'b0;
  endtask

  task automatic strobe_act(input int k);
    goto_edge(k);
    activity_in = 1'b1;
    @(posedge clk_in); #2;
    activity_in = 1'b0;
  endtask

  // Monitor: every change of {led_out, busy_out} consumes one expected event.
  initial begin
    logic [1:0] prev;
    ev_t        e;
    prev = 2'b00;
    forever begin
      @(negedge clk_in);
      if (cyc >= 1 && {led_out, busy_out} !== prev) begin
        prev = {led_out, busy_out};
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_change@%0d", cyc), {30'd0, prev}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("ev%0d_cycle", e.cyc), cyc, e.cyc);
          check($sformatf("ev%0d_led", e.cyc), {31'd0, led_out}, {31'd0, e.led});
          check($sformatf("ev%0d_busy", e.cyc), {31'd0, busy_out}, {31'd0, e.busy});
        end
      end
    end
  end

  initial begin
    // Heartbeat tracking after a 5-cycle reset: led follows pulse one cycle late.
    push(21, 1, 0); push(41, 0, 0); push(61, 1, 0); push(81, 0, 0);
    goto_edge(6);
    check("reset_led", {31'd0, led_out}, 32'd0);
    check("reset_busy", {31'd0, busy_out}, 32'd0);
    reset_in = 1'b1;

    // Code 3: three on-ticks, BLINK_OFF + 2 pause ticks dark, then repeat.
    push(85, 0, 1); push(101, 1, 1); push(122, 0, 1); push(142, 1, 1);
    push(162, 0, 1); push(182, 1, 1); push(202, 0, 1); push(262, 1, 1);
    push(282, 0, 1); push(302, 1, 1); push(322, 0, 1); push(342, 1, 1);
    strobe_err(85, 4'd3, 1'b0);
    strobe_act(130);
    strobe_act(185);

    // Clear during BLINK_ON, then clear-wins and code-0 strobes stay idle.
    push(350, 1, 0); push(361, 0, 0); push(381, 1, 0); push(401, 0, 0);
    push(421, 1, 0); push(441, 0, 0);
    strobe_clear(350);
    strobe_err(390, 4'd4, 1'b1);
    strobe_err(430, 4'd0, 1'b0);

    // Code 2 active, code 5 arrives during BLINK_ON: 2-group + pause, then 5s.
    push(445, 0, 1); push(461, 1, 1); push(482, 0, 1); push(502, 1, 1);
    push(522, 0, 1); push(582, 1, 1); push(602, 0, 1); push(622, 1, 1);
    push(642, 0, 1); push(662, 1, 1); push(682, 0, 1); push(702, 1, 1);
    push(722, 0, 1); push(742, 1, 1); push(762, 0, 1); push(822, 1, 1);
    strobe_err(445, 4'd2, 1'b0);
    strobe_err(470, 4'd5, 1'b0);

    push(830, 1, 0); push(841, 0, 0); push(861, 1, 0);
    strobe_clear(830);

    // Code arriving on an IDLE tick is shown on the following tick.
    push(862, 1, 1); push(881, 0, 1); push(882, 1, 1); push(902, 0, 1);
    push(962, 1, 1);
    strobe_err(862, 4'd1, 1'b0);

    // Reset mid-blink leaves nothing pending.
    push(970, 0, 0); push(981, 1, 0); push(1001, 0, 0);
    goto_edge(970);
    reset_in = 1'b0;
    goto_edge(973);
    reset_in = 1'b1;

    // Activity in IDLE: retriggered flash inverts 13 cycles, single flash 8.
    push(1006, 1, 0); push(1019, 0, 0); push(1021, 1, 0);
    strobe_act(1005);
    strobe_act(1010);
    push(1031, 0, 0); push(1039, 1, 0); push(1041, 0, 0);
    strobe_act(1030);

    goto_edge(1060);
    check("events_outstanding", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_blink_coder.md
LED_BLINK_CODER -- requirements
Module: led_blink_coder

Interface
REQ-001 The block SHALL have parameter PAUSE_TICKS, default 4, giving the number of heartbeat ticks of LED-off gap between code repetitions (legal range 1..15).
REQ-002 The block SHALL have parameter STRETCH_CYCLES, default 1000000, giving the activity-flash length in clk_in cycles (0.1 s at 10 MHz).
REQ-003 clk_in  input  1  single system clock (10 MHz fabric clock).
REQ-004 reset_in  input  1  reset, synchronous and active-low.
REQ-005 pulse_in  input  1  heartbeat square wave from the heartbeat block.
REQ-006 err_code_in  input  4  error code to display; 0 means "no error".
REQ-007 err_valid_in  input  1  one-cycle strobe qualifying err_code_in.
REQ-008 err_clear_in  input  1  one-cycle strobe that cancels error display.
REQ-009 activity_in  input  1  one-cycle activity strobe (e.g. frame captured).
REQ-010 led_out  output  1  registered LED drive, 1 = LED on.
REQ-011 busy_out  output  1  registered; 1 while any error code is displayed or pending.

Function
REQ-012 Tick: pulse_in SHALL be registered once, and a tick SHALL be generated on every edge (rising or falling) of the registered copy, one cycle after the edge is seen.
REQ-013 FSM states SHALL be IDLE, BLINK_ON, BLINK_OFF and PAUSE.
REQ-014 IDLE: led_out SHALL equal the registered pulse_in XOR stretch_active, so activity inverts the heartbeat.
REQ-015 Activity: activity_in SHALL load the stretch counter with STRETCH_CYCLES; stretch_active is 1 while the counter is nonzero; a retrigger reloads it; a count of 0 deasserts stretch_active.
REQ-016 Error accept: err_valid_in with a nonzero code SHALL be written into the pending register; a code of 0 SHALL be ignored.
REQ-017 IDLE -> BLINK_ON SHALL occur on the first tick with pending valid; pending moves to the active code, and the blink counter loads the active code.
REQ-018 BLINK_ON: led_out = 1 for exactly one tick interval; on the next tick the FSM SHALL go to BLINK_OFF.
REQ-019 BLINK_OFF: led_out = 0; on the next tick, decrement the blink counter; if the result is 0, go to PAUSE with the pause counter = PAUSE_TICKS; otherwise return to BLINK_ON.
REQ-020 PAUSE: led_out = 0; decrement on each tick; at 0 reload from pending if valid, otherwise reuse the active code, then go to BLINK_ON (the code repeats indefinitely).
REQ-021 A new err_valid_in during BLINK_ON/BLINK_OFF/PAUSE SHALL overwrite pending only; the code change SHALL take effect solely at the end of PAUSE.
REQ-022 err_clear_in SHALL invalidate pending and active, and force IDLE on the next cycle from any state, with led_out following REQ-014.
REQ-023 err_clear_in and err_valid_in in the same cycle: clear SHALL win and the code is discarded.
REQ-024 activity_in outside IDLE SHALL still restart the stretch counter but SHALL NOT alter led_out.
REQ-025 busy_out = (state != IDLE) OR pending valid.
REQ-026 If a tick and err_valid_in occur in the same cycle in IDLE, the new code SHALL be captured in pending and displayed at the following tick.

Reset
REQ-027 While reset_in = 0 at a clk_in edge, the block SHALL set: state = IDLE, pending/active invalid, all counters 0, the pulse register 0, led_out = 0, busy_out = 0.
REQ-028 Reset asserted mid-blink SHALL abort the sequence with no residual pending code.

Structure
REQ-029 State encoding, CODE_WIDTH = 4 and the STRETCH_CYCLES/PAUSE_TICKS defaults SHALL live in a shared status_led_pkg, shared with heartbeat users.
REQ-030 The stretch counter SHALL be a sub-module named pulse_stretcher (inputs trig and clk/reset, output active).
REQ-031 All outputs SHALL be driven directly from flops.

Verification (bench: heartbeat stub toggling every 20 cycles, STRETCH_CYCLES = 8, PAUSE_TICKS = 2)
REQ-032 Reset: hold reset_in = 0 for 5 cycles -> led_out = 0, busy_out = 0; after release, led_out tracks pulse_in delayed by 1 cycle.
REQ-033 Code 3: err_valid_in with code 3 -> 3 on-ticks separated by off-ticks, then 2 ticks off, then repeat; busy_out = 1 throughout.
REQ-034 Code change: code 2 is active and code 5 arrives during BLINK_ON -> the current 2-blink group plus pause completes, then 5 blinks follow.
REQ-035 Clear priority: err_valid_in (code 4) and err_clear_in in the same cycle -> stays IDLE, busy_out = 0; a clear during BLINK_ON -> IDLE on the next cycle.
REQ-036 Activity: activity_in in IDLE -> led_out inverted for 8 cycles, then it tracks pulse_in; a retrigger at cycle 5 extends the inversion to cycle 13.
REQ-037 Code 0: err_valid_in with code 0 -> no state change, busy_out stays 0.
